m_datapath_p: RTL and testbench

M_DATAPATH_P -- requirements
Module: m_datapath_p

---
 rtl/m_datapath_pkg.sv | 51 +++++
 rtl/m_datapath_p_regfile.sv | 46 ++++
 rtl/m_datapath_p.sv | 191 +++++++++++++++++++
 tb/tb_m_datapath_p.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/m_datapath_pkg.sv
// Shared types and defaults for the multi-cycle datapath: ALU op codes,
// mux-select encodings and the reset / trap PC values.
package m_datapath_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_TRAP_VEC = 32'h0000_0180;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_XOR = 3'b011,
    ALU_NOR = 3'b100,
    ALU_SRL = 3'b101,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    SRCB_B       = 2'd0,
    SRCB_FOUR    = 2'd1,
    SRCB_IMM     = 2'd2,
    SRCB_IMM_SH2 = 2'd3
  } srcb_sel_e;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'd0,
    PCSRC_ALUOUT = 2'd1,
    PCSRC_JUMP   = 2'd2,
    PCSRC_REG    = 2'd3
  } pcsrc_sel_e;

  typedef enum logic [1:0] {
    REGDST_RT   = 2'd0,
    REGDST_RD   = 2'd1,
    REGDST_LINK = 2'd2,
    REGDST_ZERO = 2'd3
  } regdst_sel_e;

  typedef enum logic [1:0] {
    MTR_ALUOUT = 2'd0,
    MTR_MDR    = 2'd1,
    MTR_PC     = 2'd2,
    MTR_LUI    = 2'd3
  } mtr_sel_e;

  function automatic logic [31:0] sext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/m_datapath_p_regfile.sv
// Register file: two combinational read ports, one write port, register 0
// hard-wired to zero; addresses truncated to clog2(NREG) bits.
module regfile_p
  import m_datapath_pkg::*;
#(
  parameter int NREG = 32
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_we,
  input  logic [4:0]  i_waddr,
  input  logic [31:0] i_wdata,
  input  logic [4:0]  i_raddr_a,
  input  logic [4:0]  i_raddr_b,
  output logic [31:0] o_rdata_a,
  output logic [31:0] o_rdata_b
);

  localparam int AW = $clog2(NREG);

  logic [31:0]   r_regs [NREG];
  logic [AW-1:0] w_waddr;
  logic [AW-1:0] w_raddr_a;
  logic [AW-1:0] w_raddr_b;
  logic          w_unused_addr_bits;

  assign w_waddr            = i_waddr[AW-1:0];
  assign w_raddr_a          = i_raddr_a[AW-1:0];
  assign w_raddr_b          = i_raddr_b[AW-1:0];
  assign w_unused_addr_bits = ^{i_waddr, i_raddr_a, i_raddr_b};

  // Storage: async clear, writes to register 0 dropped
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= 32'h0;
      end
    end else if (i_we && (w_waddr != {AW{1'b0}})) begin
      r_regs[w_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = (w_raddr_a == {AW{1'b0}}) ? 32'h0 : r_regs[w_raddr_a];
  assign o_rdata_b = (w_raddr_b == {AW{1'b0}}) ? 32'h0 : r_regs[w_raddr_b];

endmodule

// File: rtl/m_datapath_p.sv
// Multi-cycle MIPS-style datapath: PC/IR/MDR/A/B/ALUOut, inline ALU and muxes.
// Optional overflow trap (EPC, trap pulse) enabled by M_DATAPATH_OVF_TRAP_EN.
module m_datapath_p
  import m_datapath_pkg::*;
#(
  parameter int          NREG     = 32,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [31:0] TRAP_VEC = DEFAULT_TRAP_VEC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MIO_ready,
  input  logic        IorD,
  input  logic        IRWrite,
  input  logic        RegWrite,
  input  logic        ALUSrcA,
  input  logic        PCWrite,
  input  logic        PCWriteCond,
  input  logic        Branch,
  input  logic        BranchNE,
  input  logic [1:0]  RegDst,
  input  logic [1:0]  MemtoReg,
  input  logic [1:0]  ALUSrcB,
  input  logic [1:0]  PCSource,
  input  logic [2:0]  ALU_operation,
  input  logic [31:0] data2CPU,
  output logic [31:0] PC_Current,
  output logic [31:0] Inst,
  output logic [31:0] data_out,
  output logic [31:0] M_addr,
  output logic        zero,
  output logic        overflow,
  output logic        trap
);

  logic [31:0] r_pc, r_ir, r_mdr, r_a, r_b, r_aluout;
  logic [31:0] w_rdata_a, w_rdata_b, w_src_a, w_src_b, w_alu_res;
  logic [31:0] w_imm_ext, w_pc_next, w_wdata;
  logic [4:0]  w_waddr;
  logic        w_alu_ovf, w_taken, w_pc_we, w_trap_take, w_reg_we;

  assign w_imm_ext = sext16(r_ir[15:0]);

  // ALU operand selection
  always_comb begin
    w_src_a = ALUSrcA ? r_pc : r_a;
    w_src_b = r_b;
    case (srcb_sel_e'(ALUSrcB))
      SRCB_B:       w_src_b = r_b;
      SRCB_FOUR:    w_src_b = 32'd4;
      SRCB_IMM:     w_src_b = w_imm_ext;
      SRCB_IMM_SH2: w_src_b = {w_imm_ext[29:0], 2'b00};
      default:      w_src_b = r_b;
    endcase
  end

  // ALU; overflow only meaningful for signed add/sub
  always_comb begin
    w_alu_res = 32'h0;
    w_alu_ovf = 1'b0;
    case (alu_op_e'(ALU_operation))
      ALU_AND: w_alu_res = w_src_a & w_src_b;
      ALU_OR:  w_alu_res = w_src_a | w_src_b;
      ALU_ADD: begin
        w_alu_res = w_src_a + w_src_b;
        w_alu_ovf = (w_src_a[31] == w_src_b[31]) && (w_alu_res[31] != w_src_a[31]);
      end
      ALU_XOR: w_alu_res = w_src_a ^ w_src_b;
      ALU_NOR: w_alu_res = ~(w_src_a | w_src_b);
      ALU_SRL: w_alu_res = w_src_b >> w_src_a[4:0];
      ALU_SUB: begin
        w_alu_res = w_src_a - w_src_b;
        w_alu_ovf = (w_src_a[31] != w_src_b[31]) && (w_alu_res[31] != w_src_a[31]);
      end
      ALU_SLT: w_alu_res = ($signed(w_src_a) < $signed(w_src_b)) ? 32'd1 : 32'd0;
      default: w_alu_res = 32'h0;
    endcase
  end

  assign zero     = (w_alu_res == 32'h0);
  assign overflow = w_alu_ovf;
  assign w_taken  = Branch && (zero ^ BranchNE);
  assign w_pc_we  = MIO_ready && (PCWrite || (PCWriteCond && w_taken));

  // Next-PC source selection
  always_comb begin
    w_pc_next = w_alu_res;
    case (pcsrc_sel_e'(PCSource))
      PCSRC_ALU:    w_pc_next = w_alu_res;
      PCSRC_ALUOUT: w_pc_next = r_aluout;
      PCSRC_JUMP:   w_pc_next = {r_pc[31:28], r_ir[25:0], 2'b00};
      PCSRC_REG:    w_pc_next = r_a;
      default:      w_pc_next = w_alu_res;
    endcase
  end

  // Write-back address and data selection
  always_comb begin
    w_waddr = r_ir[20:16];
    w_wdata = r_aluout;
    case (regdst_sel_e'(RegDst))
      REGDST_RT:   w_waddr = r_ir[20:16];
      REGDST_RD:   w_waddr = r_ir[15:11];
      REGDST_LINK: w_waddr = 5'(NREG - 1);
      REGDST_ZERO: w_waddr = 5'd0;
      default:     w_waddr = r_ir[20:16];
    endcase
    case (mtr_sel_e'(MemtoReg))
      MTR_ALUOUT: w_wdata = r_aluout;
      MTR_MDR:    w_wdata = r_mdr;
      MTR_PC:     w_wdata = r_pc;
      MTR_LUI:    w_wdata = {r_ir[15:0], 16'h0};
      default:    w_wdata = r_aluout;
    endcase
  end

`ifdef M_DATAPATH_OVF_TRAP_EN
  logic r_ovf, r_trap;
  logic [31:0] r_epc;

  // The overflow flag travels with ALUOut so the write-back cycle can trap
  assign w_trap_take = RegWrite && (mtr_sel_e'(MemtoReg) == MTR_ALUOUT) && r_ovf;

  // Trap bookkeeping: registered overflow, EPC capture, trap pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ovf  <= 1'b0;
      r_trap <= 1'b0;
      r_epc  <= 32'h0;
    end else begin
      r_ovf  <= w_alu_ovf;
      r_trap <= w_trap_take;
      if (w_trap_take) begin
        r_epc <= r_pc;
      end
    end
  end

  assign trap = r_trap;
`else
  assign w_trap_take = 1'b0;
  assign trap        = 1'b0;
`endif

  assign w_reg_we = RegWrite && !w_trap_take;

  regfile_p #(.NREG(NREG)) u_regfile (
    .i_clk     (clk),
    .i_rst_n   (reset),
    .i_we      (w_reg_we),
    .i_waddr   (w_waddr),
    .i_wdata   (w_wdata),
    .i_raddr_a (r_ir[25:21]),
    .i_raddr_b (r_ir[20:16]),
    .o_rdata_a (w_rdata_a),
    .o_rdata_b (w_rdata_b)
  );

  // Architectural registers; PC and IR only move on a completed access
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc     <= RESET_PC;
      r_ir     <= 32'h0;
      r_mdr    <= 32'h0;
      r_a      <= 32'h0;
      r_b      <= 32'h0;
      r_aluout <= 32'h0;
    end else begin
      r_a      <= w_rdata_a;
      r_b      <= w_rdata_b;
      r_aluout <= w_alu_res;
      if (MIO_ready) begin
        r_mdr <= data2CPU;
      end
      if (IRWrite && MIO_ready) begin
        r_ir <= data2CPU;
      end
      if (w_trap_take) begin
        r_pc <= TRAP_VEC;
      end else if (w_pc_we) begin
        r_pc <= w_pc_next;
      end
    end
  end

  assign PC_Current = r_pc;
  assign Inst       = r_ir;
  assign data_out   = r_b;
  assign M_addr     = IorD ? r_aluout : r_pc;

endmodule

// File: tb/tb_m_datapath_p.sv
// Self-checking bench for m_datapath_p (NREG=16, RESET_PC=0x100): cycle model
// plus directed vectors; M_DATAPATH_OVF_TRAP_EN selects the trap expectations.
module tb_m_datapath_p;

  localparam int          NREG = 16;
  localparam logic [31:0] RPC  = 32'h0000_0100;
  localparam logic [31:0] TVEC = 32'h0000_0180;

  logic        clk, reset, MIO_ready, IorD, IRWrite, RegWrite, ALUSrcA;
  logic        PCWrite, PCWriteCond, Branch, BranchNE;
  logic [1:0]  RegDst, MemtoReg, ALUSrcB, PCSource;
  logic [2:0]  ALU_operation;
  logic [31:0] data2CPU, PC_Current, Inst, data_out, M_addr;
  logic        zero, overflow, trap;

  m_datapath_p #(.NREG(NREG), .RESET_PC(RPC), .TRAP_VEC(TVEC)) dut (
    .clk(clk), .reset(reset), .MIO_ready(MIO_ready), .IorD(IorD),
    .IRWrite(IRWrite), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .Branch(Branch),
    .BranchNE(BranchNE), .RegDst(RegDst), .MemtoReg(MemtoReg),
    .ALUSrcB(ALUSrcB), .PCSource(PCSource), .ALU_operation(ALU_operation),
    .data2CPU(data2CPU), .PC_Current(PC_Current), .Inst(Inst),
    .data_out(data_out), .M_addr(M_addr), .zero(zero),
    .overflow(overflow), .trap(trap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] m_pc, m_ir, m_mdr, m_a, m_b, m_aluout, m_epc;
  logic        m_ovf_r, m_trap;
  logic [31:0] m_regs [NREG];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void alu_model(input logic [2:0] op, input logic [31:0] a,
                                    input logic [31:0] b, output logic [31:0] r,
                                    output logic v);
    longint sa, sb, s;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    v  = 1'b0;
    case (op)
      3'd0: r = a & b;
      3'd1: r = a | b;
      3'd2: begin s = sa + sb; r = a + b; v = (s != longint'($signed(r))); end
      3'd3: r = a ^ b;
      3'd4: r = ~(a | b);
      3'd5: r = b >> a[4:0];
      3'd6: begin s = sa - sb; r = a - b; v = (s != longint'($signed(r))); end
      default: r = (sa < sb) ? 32'd1 : 32'd0;
    endcase
  endfunction

  function automatic void model_alu_now(output logic [31:0] r, output logic v);
    logic [31:0] sa, sb, imm;
    imm = {{16{m_ir[15]}}, m_ir[15:0]};
    sa  = ALUSrcA ? m_pc : m_a;
    case (ALUSrcB)
      2'd0: sb = m_b;
      2'd1: sb = 32'd4;
      2'd2: sb = imm;
      default: sb = imm * 32'd4;
    endcase
    alu_model(ALU_operation, sa, sb, r, v);
  endfunction

  task automatic reset_model();
    m_pc = RPC; m_ir = 32'h0; m_mdr = 32'h0; m_a = 32'h0; m_b = 32'h0;
    m_aluout = 32'h0; m_epc = 32'h0; m_ovf_r = 1'b0; m_trap = 1'b0;
    for (int i = 0; i < NREG; i++) m_regs[i] = 32'h0;
  endtask

  task automatic check_all();
    logic [31:0] r;
    logic        v;
    model_alu_now(r, v);
    chk("pc", PC_Current, m_pc);
    chk("inst", Inst, m_ir);
    chk("data_out", data_out, m_b);
    chk("m_addr", M_addr, IorD ? m_aluout : m_pc);
    chk("zero", {31'b0, zero}, {31'b0, (r == 32'h0)});
    chk("overflow", {31'b0, overflow}, {31'b0, v});
    chk("trap", {31'b0, trap}, {31'b0, m_trap});
  endtask

  // One clock: compare, advance the model, let the DUT take the edge
  task automatic cyc();
    logic [31:0] r, wd, npc, na, nb;
    logic        v, tk, tt;
    int          wa;
    #1;
    check_all();
    model_alu_now(r, v);
    tk = Branch && ((r == 32'h0) ^ BranchNE);
    tt = 1'b0;
`ifdef M_DATAPATH_OVF_TRAP_EN
    tt = RegWrite && (MemtoReg == 2'd0) && m_ovf_r;
`endif
    case (RegDst)
      2'd0: wa = int'(m_ir[20:16]);
      2'd1: wa = int'(m_ir[15:11]);
      2'd2: wa = NREG - 1;
      default: wa = 0;
    endcase
    wa = wa % NREG;
    case (MemtoReg)
      2'd0: wd = m_aluout;
      2'd1: wd = m_mdr;
      2'd2: wd = m_pc;
      default: wd = {m_ir[15:0], 16'h0};
    endcase
    na = m_regs[int'(m_ir[25:21]) % NREG];
    nb = m_regs[int'(m_ir[20:16]) % NREG];
    npc = m_pc;
    if (tt) npc = TVEC;
    else if (MIO_ready && (PCWrite || (PCWriteCond && tk))) begin
      case (PCSource)
        2'd0: npc = r;
        2'd1: npc = m_aluout;
        2'd2: npc = {m_pc[31:28], m_ir[25:0], 2'b00};
        default: npc = m_a;
      endcase
    end
    @(posedge clk);
    if (RegWrite && !tt && wa != 0) m_regs[wa] = wd;
    if (tt) m_epc = m_pc;
    if (IRWrite && MIO_ready) m_ir = data2CPU;
    if (MIO_ready) m_mdr = data2CPU;
    m_pc = npc; m_a = na; m_b = nb; m_aluout = r; m_ovf_r = v; m_trap = tt;
    @(negedge clk);
  endtask

  task automatic idle();
    MIO_ready = 1'b0; IorD = 1'b0; IRWrite = 1'b0; RegWrite = 1'b0;
    ALUSrcA = 1'b0; PCWrite = 1'b0; PCWriteCond = 1'b0; Branch = 1'b0;
    BranchNE = 1'b0; RegDst = 2'd0; MemtoReg = 2'd0; ALUSrcB = 2'd0;
    PCSource = 2'd0; ALU_operation = 3'd0; data2CPU = 32'h0;
  endtask

  task automatic load_ir(input logic [31:0] v);
    idle(); IRWrite = 1'b1; MIO_ready = 1'b1; data2CPU = v;
    cyc(); idle();
  endtask

  // Write via MDR write-back; leaves IR pointing rt at the register and B showing it
  task automatic write_reg(input logic [4:0] r, input logic [31:0] v);
    load_ir({6'h23, 5'd0, r, 16'h0});
    MIO_ready = 1'b1; data2CPU = v; cyc(); idle();
    RegWrite = 1'b1; MemtoReg = 2'd1; cyc(); idle();
    cyc();
  endtask

  logic [31:0] exp_alu [8];

  initial begin
    exp_alu[0] = 32'h0000_0000; exp_alu[1] = 32'h8000_00F4;
    exp_alu[2] = 32'h8000_00F4; exp_alu[3] = 32'h8000_00F4;
    exp_alu[4] = 32'h7FFF_FF0B; exp_alu[5] = 32'h0800_000F;
    exp_alu[6] = 32'h7FFF_FF14; exp_alu[7] = 32'h0000_0000;
    idle(); reset = 1'b0; reset_model();
    repeat (2) @(negedge clk);
    #1;
    chk("reset_pc", PC_Current, 32'h0000_0100);
    chk("reset_inst", Inst, 32'h0);
    reset = 1'b1;

    // IR fetch stalled by MIO_ready, then completes with PC+4
    IRWrite = 1'b1; data2CPU = 32'h2001_0005; PCWrite = 1'b1; ALUSrcA = 1'b1;
    ALUSrcB = 2'd1; ALU_operation = 3'd2; PCSource = 2'd0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stall_pc", PC_Current, 32'h0000_0100);
      chk("stall_inst", Inst, 32'h0);
    end
    MIO_ready = 1'b1; cyc(); idle();
    chk("fetch_inst", Inst, 32'h2001_0005);
    chk("fetch_pc", PC_Current, 32'h0000_0104);

    // Branch: A=B=7; bne not taken, beq taken to ALUOut
    write_reg(5'd1, 32'd7);
    write_reg(5'd2, 32'd7);
    load_ir({6'h05, 5'd1, 5'd2, 16'h0010}); cyc();
    for (int k = 0; k < 2; k++) begin
      ALUSrcA = 1'b1; ALUSrcB = 2'd3; ALU_operation = 3'd2; cyc(); idle();
      ALU_operation = 3'd6; PCWriteCond = 1'b1; Branch = 1'b1; PCSource = 2'd1;
      MIO_ready = 1'b1; BranchNE = (k == 0);
      cyc(); idle();
      chk(k == 0 ? "bne_pc" : "beq_pc", PC_Current, k == 0 ? 32'h0000_0104 : 32'h0000_0144);
    end

    // jal links into R15, jumps to {PC[31:28], target, 00}
    load_ir({6'h03, 26'h000_0040});
    RegDst = 2'd2; MemtoReg = 2'd2; RegWrite = 1'b1; PCWrite = 1'b1;
    PCSource = 2'd2; MIO_ready = 1'b1; cyc(); idle();
    chk("jal_pc", PC_Current, 32'h0000_0100);
    load_ir({6'h23, 5'd0, 5'd15, 16'h0}); cyc();
    chk("jal_link", data_out, 32'h0000_0144);

    // R0 discards writes; address 17 truncates to R1
    write_reg(5'd0, 32'hDEAD_BEEF);
    chk("r0_zero", data_out, 32'h0);
    write_reg(5'd17, 32'h1234_5678);
    load_ir({6'h23, 5'd0, 5'd1, 16'h0}); cyc();
    chk("trunc_r1", data_out, 32'h1234_5678);

    // lui write-back
    load_ir({6'h0f, 5'd0, 5'd4, 16'hABCD});
    RegWrite = 1'b1; MemtoReg = 2'd3; cyc(); idle(); cyc();
    chk("lui", data_out, 32'hABCD_0000);

    // ALU sweep: A=4, B=0x800000F0, result seen through M_addr (ALUOut)
    write_reg(5'd5, 32'd4);
    write_reg(5'd6, 32'h8000_00F0);
    load_ir({6'h00, 5'd5, 5'd6, 16'h0}); cyc();
    for (int op = 0; op < 8; op++) begin
      ALU_operation = 3'(op); IorD = 1'b1; cyc();
      chk("alu_res", M_addr, exp_alu[op]);
    end
    idle();

    // Overflow: 0x7FFFFFFF + 1 then write-back into R3
    write_reg(5'd1, 32'h7FFF_FFFF);
    load_ir({6'h08, 5'd1, 5'd3, 16'h0001}); cyc();
    ALU_operation = 3'd2; ALUSrcB = 2'd2;
    #1 chk("ovf_flag", {31'b0, overflow}, 32'h1);
    cyc(); idle();
    RegWrite = 1'b1; MemtoReg = 2'd0; cyc(); idle();
`ifdef M_DATAPATH_OVF_TRAP_EN
    chk("trap_pulse", {31'b0, trap}, 32'h1);
    chk("trap_pc", PC_Current, 32'h0000_0180);
    chk("trap_epc", dut.r_epc, 32'h0000_0100);
    cyc();
    chk("trap_end", {31'b0, trap}, 32'h0);
    chk("trap_nowrite", data_out, 32'h0);
`else
    chk("no_trap", {31'b0, trap}, 32'h0);
    cyc();
    chk("ovf_write", data_out, 32'h8000_0000);
`endif

    // Asynchronous reset mid-run
    #3 reset = 1'b0;
    #1;
    chk("async_pc", PC_Current, 32'h0000_0100);
    chk("async_inst", Inst, 32'h0);
    chk("async_b", data_out, 32'h0);
    chk("async_trap", {31'b0, trap}, 32'h0);
    reset_model();
    @(negedge clk);
    reset = 1'b1;
    load_ir({6'h23, 5'd0, 5'd1, 16'h0}); cyc();
    chk("reset_regs", data_out, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
